// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative multiply/divide sequencer owning the HI/LO register
//               pair. Radix-2 LSB-first shift-add multiply and restoring
//               divide on operand magnitudes, followed by one sign-fix cycle.
//               Holds stall high while a result is pending.
// Config      : MULDIV_DIV_EN - when defined, the divider datapath and
//               DIV/DIVU are built in; otherwise any divide request
//               finishes at once with dz=1 and HI/LO unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         hi_we,
   input  logic         lo_we,
   input  logic [N-1:0] wdata,
   output logic         busy,
   output logic         stall,
   output logic         done,
   output logic         dz,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   localparam int c_cnt_w = $clog2(N) + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [N-1:0]       opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [2*N-1:0]     acc_q, acc_d;       // {upper, lower} working register
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic [N-1:0]       hi_q, hi_d;
   logic [N-1:0]       lo_q, lo_d;
   logic               dz_q, dz_d;

   logic [N-1:0]       w_a_mag;
   logic [N-1:0]       w_b_mag;
   logic               w_div_trap;
   logic [N:0]         w_mul_sum;
   logic [2*N-1:0]     w_mul_step;
   logic [2*N-1:0]     w_prod;
   logic [N-1:0]       w_fix_hi;
   logic [N-1:0]       w_fix_lo;

   // Operand magnitudes for signed ops, and the immediate-finish condition
   always_comb begin
      w_a_mag = (op[0] & a[N-1]) ? -a : a;
      w_b_mag = (op[0] & b[N-1]) ? -b : b;
`ifdef MULDIV_DIV_EN
      w_div_trap = op[1] & (b == '0);
`else
      w_div_trap = op[1];
`endif
   end

   // One shift-add multiply step: add multiplicand if the multiplier LSB is set
   always_comb begin
      w_mul_sum  = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? opnd_q : {N{1'b0}})};
      w_mul_step = {w_mul_sum, acc_q[N-1:1]};
   end

`ifdef MULDIV_DIV_EN
   logic [N:0]     w_div_shift;
   logic [N:0]     w_div_trial;
   logic [2*N-1:0] w_div_step;

   // One restoring divide step: shift in the next dividend bit, keep the
   // difference only when it does not go negative
   always_comb begin
      w_div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
      w_div_trial = w_div_shift - {1'b0, opnd_q};
      if (w_div_trial[N]) begin
         w_div_step = {w_div_shift[N-1:0], acc_q[N-2:0], 1'b0};
      end else begin
         w_div_step = {w_div_trial[N-1:0], acc_q[N-2:0], 1'b1};
      end
   end
`endif

   // Sign correction of the raw magnitude result into HI/LO values
   always_comb begin
      w_prod   = acc_q;
      w_fix_hi = acc_q[2*N-1:N];
      w_fix_lo = acc_q[N-1:0];
      if (op_q[1]) begin
`ifdef MULDIV_DIV_EN
         // Quotient negated on sign mismatch; remainder follows the dividend
         w_fix_lo = (op_q[0] & (sign_a_q ^ sign_b_q)) ? -acc_q[N-1:0] : acc_q[N-1:0];
         w_fix_hi = (op_q[0] & sign_a_q) ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
`else
         w_fix_hi = hi_q;
         w_fix_lo = lo_q;
`endif
      end else begin
         w_prod   = (op_q[0] & (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
         w_fix_hi = w_prod[2*N-1:N];
         w_fix_lo = w_prod[N-1:0];
      end
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dz_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // A start in the same cycle as MTHI/MTLO takes priority
               if (w_div_trap) begin
                  state_d = S_DONE;
                  dz_d    = 1'b1;
               end else begin
                  op_d     = op;
                  sign_a_d = op[0] & a[N-1];
                  sign_b_d = op[0] & b[N-1];
                  cnt_d    = '0;
                  state_d  = S_RUN;
                  if (op[1]) begin
                     opnd_d = w_b_mag;
                     acc_d  = {{N{1'b0}}, w_a_mag};
                  end else begin
                     opnd_d = w_a_mag;
                     acc_d  = {{N{1'b0}}, w_b_mag};
                  end
               end
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_DIV_EN
            acc_d = op_q[1] ? w_div_step : w_mul_step;
`else
            acc_d = w_mul_step;
`endif
            if (cnt_q == c_cnt_last) state_d = S_FIX;
         end
         S_FIX: begin
            hi_d    = w_fix_hi;
            lo_d    = w_fix_lo;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dz_q     <= dz_d;
      end
   end

   assign busy  = (state_q == S_RUN) || (state_q == S_FIX);
   assign done  = (state_q == S_DONE);
   assign dz    = dz_q;
   assign stall = busy | (start & (state_q == S_IDLE));
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq. Directed cases plus
//               random operations compared against a 64-bit arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        stall;
   logic        done;
   logic        dz;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   muldiv_seq #(.N(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .stall (stall),
      .done  (done),
      .dz    (dz),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Reference model: architectural result of one operation on HI/LO
   task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        inout logic [31:0] mh, inout logic [31:0] ml,
                        output bit mdz, output int lat);
      longint      sx, sy, q, r;
      logic [63:0] p;
      logic [63:0] q64;
      logic [63:0] r64;
      mdz = 1'b0;
      lat = 33;
      if (o[1]) begin
`ifdef MULDIV_DIV_EN
         if (y == 32'd0) begin
            mdz = 1'b1;
            lat = 0;
         end else if (o[0]) begin
            sx  = longint'($signed(x));
            sy  = longint'($signed(y));
            q   = sx / sy;
            r   = sx % sy;
            q64 = q;
            r64 = r;
            ml  = q64[31:0];
            mh  = r64[31:0];
         end else begin
            ml = x / y;
            mh = x % y;
         end
`else
         mdz = 1'b1;
         lat = 0;
`endif
      end else begin
         if (o[0]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = sx * sy;
         end else begin
            p = 64'(x) * 64'(y);
         end
         mh = p[63:32];
         ml = p[31:0];
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit inject);
      bit e_dz;
      int e_lat;
      int k;
      bit stall_ok;
      model(o, x, y, exp_hi, exp_lo, e_dz, e_lat);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (inject) begin
         hi_we = 1'b1;
         wdata = 32'h55;
      end
      #1 check({tag, " stall@start"}, 64'(stall), 64'd1);
      @(posedge clk);
      #1;
      start    = 1'b0;
      hi_we    = 1'b0;
      k        = 0;
      stall_ok = 1'b1;
      while (!done && k < 100) begin
         if (!stall) stall_ok = 1'b0;
         if (inject) begin
            lo_we = (k < 5);
            wdata = 32'hAA;
         end
         @(posedge clk);
         #1;
         k++;
      end
      lo_we = 1'b0;
      check({tag, " latency"}, 64'(k), 64'(e_lat));
      check({tag, " stall held"}, 64'(stall_ok), 64'd1);
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " dz"}, 64'(dz), 64'(e_dz));
      check({tag, " stall@done"}, 64'(stall), 64'd0);
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
      @(posedge clk);
      #1;
      check({tag, " done cleared"}, 64'(done), 64'd0);
      check({tag, " busy idle"}, 64'(busy), 64'd0);
   endtask

   task automatic mtx(input bit hw, input bit lw, input logic [31:0] d);
      @(negedge clk);
      hi_we = hw;
      lo_we = lw;
      wdata = d;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (hw) exp_hi = d;
      if (lw) exp_lo = d;
      check("mt hi", 64'(hi), 64'(exp_hi));
      check("mt lo", 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      int  k;
      bit  seen;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      reset = 1'b1;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst dz", 64'(dz), 64'd0);
      check("rst stall", 64'(stall), 64'd0);
      reset = 1'b0;

      run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu max hi const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      check("multu max lo const", 64'(lo), 64'h0000_0000_0000_0001);
      run_op("mult -3*7", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
      check("mult -3*7 lo const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
      run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 1'b0);
      run_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      mtx(1'b1, 1'b0, 32'h1234);
      mtx(1'b0, 1'b1, 32'h5678);
      mtx(1'b1, 1'b1, 32'hCAFE_F00D);
      mtx(1'b1, 1'b0, 32'h1234);
      run_op("divu by 0", 2'b10, 32'd100, 32'd0, 1'b0);
      check("divu by 0 hi kept", 64'(hi), 64'h1234);

      // Reset during an in-flight multiply discards it
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      a     = 32'd5;
      b     = 32'd6;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst done", 64'(done), 64'd0);
      check("midrst hi", 64'(hi), 64'd0);
      check("midrst lo", 64'(lo), 64'd0);
      reset  = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      seen   = 1'b0;
      for (k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("midrst no done", 64'(seen), 64'd0);

      // MTHI with start and MTLO during RUN are both dropped
      run_op("write drop", 2'b00, 32'd5, 32'd6, 1'b1);
      check("write drop lo const", 64'(lo), 64'd30);

      for (int i = 0; i < 16; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 5) == 0) rb = 32'd0;
         else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
         run_op("random", ro, ra, rb, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
